cp0_reg: RTL and testbench



---
 rtl/cp0_reg_pkg.sv | 57 +++++
 rtl/cp0_reg.sv | 113 +++++++++++
 tb/tb_cp0_reg.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register addresses, exception types, field positions.
package cp0_reg_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 5;

  // CP0 register addresses (rd field of MTC0/MFC0)
  localparam logic [ADDR_W-1:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [ADDR_W-1:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [ADDR_W-1:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_REG_EPC     = 5'd14;
  localparam logic [ADDR_W-1:0] CP0_REG_PRID    = 5'd15;
  localparam logic [ADDR_W-1:0] CP0_REG_CONFIG  = 5'd16;

  // Exception types delivered by the MEM stage
  localparam logic [REG_W-1:0] EXC_INT     = 32'h0000_0001;
  localparam logic [REG_W-1:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [REG_W-1:0] EXC_RI      = 32'h0000_000a;
  localparam logic [REG_W-1:0] EXC_OV      = 32'h0000_000c;
  localparam logic [REG_W-1:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [REG_W-1:0] EXC_ERET    = 32'h0000_000e;

  // Status / Cause field positions
  localparam int unsigned STATUS_EXL  = 1;
  localparam int unsigned CAUSE_BD    = 31;
  localparam int unsigned CAUSE_IP_LO = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned EXC_CODE_W  = 5;

  // Software-writable Cause bits: IV, WP, IP[9:8]
  localparam logic [REG_W-1:0] CAUSE_WMASK = 32'h00c0_0300;
  localparam logic [REG_W-1:0] STATUS_RST  = 32'h1000_0000;

  typedef struct packed {
    logic                  take;   // exception that records ExcCode/EPC
    logic                  eret;   // return from exception
    logic [EXC_CODE_W-1:0] code;
  } exc_info_t;

  // Classify an exception type into take/eret/ExcCode
  function automatic exc_info_t decode_exc(input logic [REG_W-1:0] t);
    exc_info_t info;
    info = '0;
    case (t)
      EXC_INT:     begin info.take = 1'b1; info.code = 5'd0;  end
      EXC_SYSCALL: begin info.take = 1'b1; info.code = 5'd8;  end
      EXC_RI:      begin info.take = 1'b1; info.code = 5'd10; end
      EXC_OV:      begin info.take = 1'b1; info.code = 5'd12; end
      EXC_TRAP:    begin info.take = 1'b1; info.code = 5'd13; end
      EXC_ERET:    info.eret = 1'b1;
      default:     info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status/Cause/EPC, ERET.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
  parameter int unsigned INT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [31:0]       data_i,
  input  logic [4:0]        raddr_i,
  input  logic [INT_W-1:0]  int_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       current_inst_addr_i,
  input  logic              is_in_delayslot_i,
  output logic [31:0]       data_o,
  output logic [31:0]       count_o,
  output logic [31:0]       compare_o,
  output logic [31:0]       status_o,
  output logic [31:0]       cause_o,
  output logic [31:0]       epc_o,
  output logic [31:0]       config_o,
  output logic [31:0]       prid_o,
  output logic              timer_int_o
);

  logic [REG_W-1:0] count_d, compare_d, status_d, cause_d, epc_d;
  logic             timer_d;
  exc_info_t        exc;

  assign exc      = decode_exc(excepttype_i);
  assign config_o = CONFIG_VAL;
  assign prid_o   = PRID_VAL;

  // Next-state: timer/IP sampling, then MTC0 write, then exception overrides
  always_comb begin
    count_d   = count_o + 32'd1;
    compare_d = compare_o;
    status_d  = status_o;
    cause_d   = cause_o;
    epc_d     = epc_o;
    timer_d   = timer_int_o;

    if ((compare_o != '0) && (count_o == compare_o)) timer_d = 1'b1;
    cause_d[CAUSE_IP_LO +: INT_W] = int_i;

    if (we_i) begin
      case (waddr_i)
        CP0_REG_COUNT:   count_d = data_i;
        CP0_REG_COMPARE: begin
          compare_d = data_i;
          timer_d   = 1'b0;
        end
        CP0_REG_STATUS:  status_d = data_i;
        CP0_REG_CAUSE:   cause_d = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        CP0_REG_EPC:     epc_d = data_i;
        default:         ;
      endcase
    end

    if (exc.take) begin
      cause_d[CAUSE_EXC_LO +: EXC_CODE_W] = exc.code;
      // Nested exceptions keep the original EPC/BD
      if (!status_o[STATUS_EXL]) begin
        epc_d = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
    end else if (exc.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o     <= '0;
      compare_o   <= '0;
      status_o    <= STATUS_RST;
      cause_o     <= '0;
      epc_o       <= '0;
      timer_int_o <= 1'b0;
    end else begin
      count_o     <= count_d;
      compare_o   <= compare_d;
      status_o    <= status_d;
      cause_o     <= cause_d;
      epc_o       <= epc_d;
      timer_int_o <= timer_d;
    end
  end

  // MFC0 read mux from registered state; forced to zero during reset
  always_comb begin
    data_o = '0;
    if (rst_n) begin
      case (raddr_i)
        CP0_REG_COUNT:   data_o = count_o;
        CP0_REG_COMPARE: data_o = compare_o;
        CP0_REG_STATUS:  data_o = status_o;
        CP0_REG_CAUSE:   data_o = cause_o;
        CP0_REG_EPC:     data_o = epc_o;
        CP0_REG_PRID:    data_o = PRID_VAL;
        CP0_REG_CONFIG:  data_o = CONFIG_VAL;
        default:         data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Testbench for cp0_reg: directed steps plus randomized traffic vs a reference model.
module tb_cp0_reg;

  localparam logic [31:0] PRID = 32'h004c_0102;
  localparam logic [31:0] CFG  = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = 5'd15;
  logic [5:0]  int_v = '0;
  logic [31:0] exc = '0;
  logic [31:0] pc = '0;
  logic        dly = 1'b0;

  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  // Reference model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exc_tab [8] = '{32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3};
  logic [4:0]  addr_tab[8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};

  cp0_reg dut (
    .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .data_i(wdata),
    .raddr_i(raddr), .int_i(int_v), .excepttype_i(exc),
    .current_inst_addr_i(pc), .is_in_delayslot_i(dly),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
    m_cause = 0; m_epc = 0; m_timer = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CFG;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the architectural rules, using the inputs held across the edge
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_timer;
    logic        wr;
    wr        = we;
    n_count   = (wr && waddr == 5'd9)  ? wdata : m_count + 32'd1;
    n_compare = (wr && waddr == 5'd11) ? wdata : m_compare;
    n_status  = (wr && waddr == 5'd12) ? wdata : m_status;
    n_epc     = (wr && waddr == 5'd14) ? wdata : m_epc;
    n_timer   = m_timer || (m_compare != 0 && m_count == m_compare);
    if (wr && waddr == 5'd11) n_timer = 1'b0;
    n_cause   = m_cause;
    if (wr && waddr == 5'd13) n_cause = (m_cause & 32'hff3f_fcff) | (wdata & 32'h00c0_0300);
    n_cause = (n_cause & ~32'h0000_fc00) | (32'(int_v) << 10);
    if (exc inside {32'h1, 32'h8, 32'ha, 32'hc, 32'hd}) begin
      // ExcCode equals the type value, except hardware interrupt which is 0
      n_cause = (n_cause & ~32'h7c) | ((exc == 32'h1 ? 32'h0 : exc) << 2);
      if (m_status[1] == 1'b0) begin
        n_epc   = dly ? pc - 32'd4 : pc;
        n_cause = dly ? (n_cause | 32'h8000_0000) : (n_cause & 32'h7fff_ffff);
      end
      n_status = n_status | 32'h2;
    end else if (exc == 32'he) begin
      n_status = n_status & ~32'h2;
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
  endtask

  task automatic check_all();
    check("count",   count_o,   m_count);
    check("compare", compare_o, m_compare);
    check("status",  status_o,  m_status);
    check("cause",   cause_o,   m_cause);
    check("epc",     epc_o,     m_epc);
    check("timer",   32'(timer_int_o), 32'(m_timer));
    check("data_o",  data_o,    model_read(raddr));
  endtask

  task automatic check_reset_state();
    check("rst_count",  count_o,   32'h0);
    check("rst_compare", compare_o, 32'h0);
    check("rst_status", status_o,  32'h1000_0000);
    check("rst_cause",  cause_o,   32'h0);
    check("rst_epc",    epc_o,     32'h0);
    check("rst_timer",  32'(timer_int_o), 32'h0);
    check("rst_data_o", data_o,    32'h0);
    check("rst_config", config_o,  CFG);
    check("rst_prid",   prid_o,    PRID);
  endtask

  // Advance one clock, update model, check everything, drop one-shot inputs
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    we  = 1'b0;
    exc = 32'h0;
  endtask

  initial begin
    int budget;
    model_reset();

    // Reset state
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle 5 cycles
    for (int i = 0; i < 5; i++) cycle();
    check("idle_count", count_o, 32'd5);
    check("idle_prid_read", data_o, PRID);

    // Compare/timer
    raddr = 5'd11;
    budget = 20;
    while (count_o != 32'd10 && budget > 0) begin cycle(); budget--; end
    check("reach_count10", count_o, 32'd10);
    we = 1'b1; waddr = 5'd11; wdata = 32'd20;
    cycle();
    budget = 30;
    while (count_o != 32'd20 && budget > 0) begin cycle(); budget--; end
    check("reach_count20", count_o, 32'd20);
    check("timer_before", 32'(timer_int_o), 32'h0);
    cycle();
    check("timer_rise", 32'(timer_int_o), 32'h1);
    for (int i = 0; i < 3; i++) cycle();
    check("timer_hold", 32'(timer_int_o), 32'h1);
    we = 1'b1; waddr = 5'd11; wdata = 32'd0;
    cycle();
    check("timer_clear", 32'(timer_int_o), 32'h0);

    // Count wrap and write-wins-over-increment
    raddr = 5'd9;
    we = 1'b1; waddr = 5'd9; wdata = 32'hffff_fffe;
    cycle(); check("wrap_fe", count_o, 32'hffff_fffe);
    cycle(); check("wrap_ff", count_o, 32'hffff_ffff);
    cycle(); check("wrap_0",  count_o, 32'h0);
    cycle(); check("wrap_1",  count_o, 32'h1);

    // Syscall in delay slot, then nested exception
    raddr = 5'd14;
    exc = 32'h8; pc = 32'h100; dly = 1'b1;
    cycle();
    check("sys_epc", epc_o, 32'hfc);
    check("sys_bd", 32'(cause_o[31]), 32'h1);
    check("sys_code", 32'(cause_o[6:2]), 32'd8);
    check("sys_exl", 32'(status_o[1]), 32'h1);
    exc = 32'ha; pc = 32'h200; dly = 1'b0;
    cycle();
    check("nest_epc", epc_o, 32'hfc);
    check("nest_code", 32'(cause_o[6:2]), 32'd10);
    check("nest_bd", 32'(cause_o[31]), 32'h1);

    // ERET, Cause write mask, IP sampling
    exc = 32'he;
    cycle();
    check("eret_exl", 32'(status_o[1]), 32'h0);
    raddr = 5'd13;
    we = 1'b1; waddr = 5'd13; wdata = 32'hffff_ffff;
    cycle();
    check("cause_wmask", cause_o & 32'h7fff_ff83, 32'h00c0_0300);
    int_v = 6'b000101;
    cycle();
    check("cause_ip", 32'(cause_o[15:10]), 32'd5);
    int_v = 6'b0;

    // Status write and overflow in the same cycle
    raddr = 5'd12;
    we = 1'b1; waddr = 5'd12; wdata = 32'h0;
    exc = 32'hc; pc = 32'h0000_0340;
    cycle();
    check("ov_status", status_o, 32'h0000_0002);
    check("ov_code", 32'(cause_o[6:2]), 32'd12);
    check("ov_epc", epc_o, 32'h0000_0340);

    // Asynchronous reset mid-cycle
    we = 1'b1; waddr = 5'd11; wdata = m_count + 32'd2;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    check("pre_reset_timer", 32'(timer_int_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      we    = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 7) == 7) ? 5'($urandom_range(0, 31)) : addr_tab[$urandom_range(0, 6)];
      wdata = $urandom;
      if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + 32'($urandom_range(1, 6));
      if (waddr == 5'd11 && $urandom_range(0, 7) == 0) wdata = 32'h0;
      exc   = ($urandom_range(0, 2) == 0) ? exc_tab[$urandom_range(1, 7)] : 32'h0;
      pc    = $urandom & 32'hffff_fffc;
      dly   = 1'($urandom_range(0, 1));
      int_v = 6'($urandom_range(0, 63));
      raddr = ($urandom_range(0, 7) == 7) ? 5'($urandom_range(0, 31)) : addr_tab[$urandom_range(0, 7)];
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
